// File: rtl/dbg_reg_access.sv
// Debug-side GPR access engine: runs abstract-command register reads/writes
// against the core register file while the hart is halted.
module dbg_reg_access #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 32,
  parameter logic [15:0] RegBase = 16'h1000,
  localparam int unsigned AW     = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_regno,
  input  logic [Width-1:0] cmd_wdata,
  input  logic             core_halted,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             rf_sel,
  output logic [AW-1:0]    rf_rd_addr,
  input  logic [Width-1:0] rf_rd_data,
  output logic [AW-1:0]    rf_wr_addr,
  output logic [Width-1:0] rf_wr_data,
  output logic             rf_wr_en
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLAIM,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic               r_write;
  logic [AW-1:0]      r_idx;
  logic [Width-1:0]   r_wdata;
  logic [Width-1:0]   r_rdata;
  logic               r_err;

  logic [16:0]        w_off;
  logic               w_in_range;
  logic               w_cmd_ok;
  logic               w_accept;
  logic               w_abort;

  // 17-bit subtraction so a regno below RegBase wraps to a huge offset.
  assign w_off      = {1'b0, cmd_regno} - {1'b0, RegBase};
  assign w_in_range = (cmd_regno >= RegBase) && (w_off < 17'(Depth));
  assign w_cmd_ok   = w_in_range && core_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_sel    = 1'b0;
    rf_wr_en  = 1'b0;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = w_cmd_ok ? S_CLAIM : S_RESP;
        end
      end
      S_CLAIM: begin
        rf_sel = 1'b1;
        if (!core_halted) begin
          w_abort = 1'b1;
          w_next  = S_RESP;
        end else begin
          w_next  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rf_sel   = 1'b1;
        // Halt loss suppresses the write within the same cycle.
        rf_wr_en = r_write && core_halted;
        w_abort  = !core_halted;
        w_next   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_idx   <= w_off[AW-1:0];
        r_wdata <= cmd_wdata;
        r_rdata <= '0;
        r_err   <= !w_cmd_ok;
      end
      if (w_abort) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end else if (r_state == S_ACCESS && !r_write) begin
        r_rdata <= rf_rd_data;
      end
    end
  end

  assign rf_rd_addr = rf_sel   ? r_idx   : '0;
  assign rf_wr_addr = rf_sel   ? r_idx   : '0;
  assign rf_wr_data = rf_wr_en ? r_wdata : '0;
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;

endmodule

// File: tb/tb_dbg_reg_access.sv
// Directed bench for dbg_reg_access with a behavioural register file responder.
module tb_dbg_reg_access;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_regno;
  logic [31:0] cmd_wdata;
  logic        core_halted;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rf_sel;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_wr_en;

  int unsigned n_checks;
  int unsigned n_errors;

  int          m_lat;
  int          m_wr_cnt;
  int          m_wr_at;
  int          m_sel_cnt;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;

  logic [31:0] mem [32];

  dbg_reg_access #(
    .Width  (32),
    .Depth  (32),
    .RegBase(16'h1000)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_regno  (cmd_regno),
    .cmd_wdata  (cmd_wdata),
    .core_halted(core_halted),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rf_sel     (rf_sel),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_en   (rf_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: x0 hardwired to zero, combinational read.
  assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'd0 : mem[rf_rd_addr];
  always @(posedge clk) begin
    if (rf_wr_en && rf_wr_addr != 5'd0) mem[rf_wr_addr] <= rf_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drop_n: edge count after accept at which core_halted is lowered (0 = never).
  task automatic run_cmd(input string tag, input logic w, input logic [15:0] regno,
                         input logic [31:0] wd, input int drop_n, input int hold,
                         input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int   n;
    logic seen;
    n         = 0;
    seen      = 1'b0;
    m_lat     = 0;
    m_wr_cnt  = 0;
    m_wr_at   = 0;
    m_sel_cnt = 0;
    m_wr_addr = '0;
    m_wr_data = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_regno = regno;
    cmd_wdata = wd;
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) cmd_valid = 1'b0;
      if (n == drop_n) core_halted = 1'b0;
      @(negedge clk);
      if (rf_wr_en) begin
        m_wr_cnt++;
        m_wr_at   = n;
        m_wr_addr = rf_wr_addr;
        m_wr_data = rf_wr_data;
      end
      if (rf_sel) m_sel_cnt++;
      if (rsp_valid) begin
        seen  = 1'b1;
        m_lat = n;
      end
    end
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(m_lat), 32'(exp_lat));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
    core_halted = 1'b1;
    @(negedge clk);
    check({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_regno   = '0;
    cmd_wdata   = '0;
    core_halted = 1'b1;
    rsp_ready   = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rf_sel", 32'(rf_sel), 32'd0);
    check("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_cmd("wr5", 1'b1, 16'h1005, 32'hDEADBEEF, 0, 0, 3, 32'd0, 1'b0);
    check("wr5_wr_cnt", 32'(m_wr_cnt), 32'd1);
    check("wr5_wr_at", 32'(m_wr_at), 32'd2);
    check("wr5_wr_addr", 32'(m_wr_addr), 32'd5);
    check("wr5_wr_data", m_wr_data, 32'hDEADBEEF);
    check("wr5_sel_cycles", 32'(m_sel_cnt), 32'd2);
    run_cmd("rd5", 1'b0, 16'h1005, 32'd0, 0, 0, 3, 32'hDEADBEEF, 1'b0);
    check("rd5_wr_cnt", 32'(m_wr_cnt), 32'd0);

    run_cmd("rd0", 1'b0, 16'h1000, 32'd0, 0, 0, 3, 32'd0, 1'b0);
    run_cmd("wr0", 1'b1, 16'h1000, 32'h00001234, 0, 0, 3, 32'd0, 1'b0);
    run_cmd("rd0b", 1'b0, 16'h1000, 32'd0, 0, 0, 3, 32'd0, 1'b0);

    run_cmd("wr31", 1'b1, 16'h101F, 32'hA5A5A5A5, 0, 0, 3, 32'd0, 1'b0);
    check("wr31_wr_addr", 32'(m_wr_addr), 32'd31);
    run_cmd("rd31", 1'b0, 16'h101F, 32'd0, 0, 0, 3, 32'hA5A5A5A5, 1'b0);

    run_cmd("lo_oor", 1'b0, 16'h0FFF, 32'd0, 0, 0, 1, 32'd0, 1'b1);
    check("lo_oor_sel", 32'(m_sel_cnt), 32'd0);
    run_cmd("hi_oor", 1'b1, 16'h1020, 32'h77777777, 0, 0, 1, 32'd0, 1'b1);
    check("hi_oor_sel", 32'(m_sel_cnt), 32'd0);
    check("hi_oor_wr_cnt", 32'(m_wr_cnt), 32'd0);

    core_halted = 1'b0;
    run_cmd("not_halted", 1'b0, 16'h1005, 32'd0, 0, 0, 1, 32'd0, 1'b1);
    check("not_halted_sel", 32'(m_sel_cnt), 32'd0);

    run_cmd("wr7", 1'b1, 16'h1007, 32'h11111111, 0, 0, 3, 32'd0, 1'b0);
    run_cmd("wr7_drop", 1'b1, 16'h1007, 32'h55555555, 2, 0, 3, 32'd0, 1'b1);
    check("wr7_drop_wr_cnt", 32'(m_wr_cnt), 32'd0);
    run_cmd("rd7", 1'b0, 16'h1007, 32'd0, 0, 0, 3, 32'h11111111, 1'b0);

    run_cmd("rd5_claim_drop", 1'b0, 16'h1005, 32'd0, 1, 0, 2, 32'd0, 1'b1);

    run_cmd("rd5_stall", 1'b0, 16'h1005, 32'd0, 0, 10, 3, 32'hDEADBEEF, 1'b0);

    // Reset asserted while the engine is claiming the register file.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_regno = 16'h1009;
    cmd_wdata = 32'hCAFE0009;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstmid_claim_sel", 32'(rf_sel), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_sel_drop", 32'(rf_sel), 32'd0);
    check("rstmid_wr_en", 32'(rf_wr_en), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_wr_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rf_wr_en) m_wr_cnt++;
    end
    check("rstmid_no_write", 32'(m_wr_cnt), 32'd0);
    check("rstmid_cmd_ready_after", 32'(cmd_ready), 32'd1);
    run_cmd("rd9", 1'b0, 16'h1009, 32'd0, 0, 0, 3, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
